rf_scoreboard: RTL and testbench
================================

Name: rf_scoreboard

Overview:
- Read-side hazard tracker for the register file.
- Holds a per-register count of writes that have been issued but not yet written back.
- Decides whether an instruction in decode may read its source operands and claim its destination, and stalls issue otherwise.
- Sits between decode/issue (reader side) and writeback (the register file write port).

Parameters:
NUM_REGISTERS, 32, number of architectural registers; register 0 is hardwired zero and never tracked
MAX_PENDING, 3, maximum outstanding writes per register; saturation blocks further issue to that rd
OP_ADDR_WIDTH, $clog2(NUM_REGISTERS), localparam, register address width
CNT_WIDTH, $clog2(MAX_PENDING+1), localparam, per-register counter width

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
issue_valid_in  input  1  decode presents an instruction
issue_ready_out  output  1  instruction may issue this cycle (combinational)
rs1_in  input  OP_ADDR_WIDTH  source register 1 address
rs1_used_in  input  1  instruction reads rs1
rs2_in  input  OP_ADDR_WIDTH  source register 2 address
rs2_used_in  input  1  instruction reads rs2
rd_in  input  OP_ADDR_WIDTH  destination register address
rd_wr_in  input  1  instruction writes rd
wb_valid_in  input  1  writeback retires a write this cycle (same cycle as register file write enable)
wb_rd_in  input  OP_ADDR_WIDTH  register being written back
flush_in  input  1  pipeline flush; discards all pending writes
stall_out  output  1  issue_valid_in & ~issue_ready_out
busy_out  output  1  any counter nonzero (registered state)
err_out  output  1  sticky: writeback to a register with zero pending count

Behaviour:
- Reset (rst=1 at posedge): all counters 0, err_out 0. busy_out is 0 from the next cycle.
- While rst=1, issue_ready_out is forced to 0.
- Interface is synchronous, active-high reset, single clock clk.
- Release flag: rel[r] = wb_valid_in & wb_rd_in==r & cnt[r]==1.
  - The register file writes mid-cycle on the falling edge, so a matching writeback in the same cycle makes the data readable.
  - A register whose last outstanding write is retiring therefore counts as ready.
- RAW hazard: rsN_used_in & rsN_in!=0 & cnt[rsN_in]!=0 & ~rel[rsN_in], for N=1,2.
- WAW saturation: rd_wr_in & rd_in!=0 & cnt[rd_in]==MAX_PENDING & ~(wb_valid_in & wb_rd_in==rd_in).
- issue_ready_out = ~rst & ~flush_in & ~RAW1 & ~RAW2 & ~WAWsat.
  - Combinational, zero latency.
  - Independent of issue_valid_in.
- fire = issue_valid_in & issue_ready_out.
- Counter update at posedge, visible next cycle:
  - inc[r] = fire & rd_wr_in & rd_in==r & r!=0
  - dec[r] = wb_valid_in & wb_rd_in==r & r!=0 & cnt[r]!=0
  - inc & dec on the same register: unchanged. inc only: +1. dec only: -1.
- Underflow: wb_valid_in with wb_rd_in!=0 and cnt==0 sets err_out (sticky until rst); counter stays 0.
- Writeback to register 0: ignored, no error.
- Flush: all counters cleared at posedge; the same-cycle writeback and issue are ignored.
  - Later writebacks from squashed instructions hit zero counters and set err_out. The pipeline must drain or suppress them.
- Counter 0 and its inc/dec logic are tied off (constant 0).
- rs1_in==rs2_in==rd_in on one instruction is legal; hazards are evaluated before the increment.

Decomposition:
- Package rf_pkg:
  - NUM_REGISTERS, OP_ADDR_WIDTH constants
  - reg_addr_t typedef
  - ZERO_REG constant
  - shared with the register file, decode and writeback
- Sub-module reg_pending_counter:
  - one counter, CNT_WIDTH bits
  - inputs inc, dec, clr; outputs count, is_zero, is_one, is_max
  - underflow-safe
  - instantiated NUM_REGISTERS-1 times via generate
- Top level holds the hazard compare, the issue handshake and err/busy reduction.

Test Plan:
- rst=1 for 2 cycles with issue_valid_in=1 -> issue_ready_out=0 throughout; after release: busy_out=0, err_out=0, issue_ready_out=1 for any operands.
- Issue rd=5 (fire), next cycle rs1=5 used -> issue_ready_out=0, stall_out=1. wb_valid_in/wb_rd_in=5 in the stalled cycle -> issue_ready_out=1 that same cycle. busy_out=0 after.
- Issue rd=7 three times, fourth issue rd=7 with no wb -> issue_ready_out=0 (saturated). Same with wb_rd_in=7 -> fires; count stays 3.
- Issue rd=0 and rs1=rs2=0 repeatedly -> always ready, busy_out stays 0. wb_rd_in=0 -> err_out stays 0.
- Issue rd=3 and rd=4, assert flush_in -> issue_ready_out=0 in the flush cycle; busy_out=0 next cycle. Then wb_rd_in=3 -> err_out=1, held until rst.
- Same cycle: issue rd=9 and wb_rd_in=9 with cnt[9]=2 -> cnt[9] stays 2. Then rs2=9 with wb_rd_in=9 -> stall, because the count is 2, not 1.

Source files
------------

// File: rtl/rf_pkg.sv
// Register-file shared definitions.
// Used by the register file, decode, writeback and the issue scoreboard.
package rf_pkg;

  localparam int NUM_REGISTERS = 32;
  localparam int OP_ADDR_WIDTH = $clog2(NUM_REGISTERS);

  typedef logic [OP_ADDR_WIDTH-1:0] reg_addr_t;

  // Register 0 is hardwired to zero and never tracked for hazards.
  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_pending_counter.sv
// Pending-write counter for one architectural register.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   inc_i             a write to this register issued this cycle
//   dec_i             a write to this register retired this cycle
//   clr_i             discard all pending writes (flush)
//   count_o           current pending count
//   is_zero_o         count == 0
//   is_one_o          count == 1
//   is_max_o          count == MAX_PENDING
module reg_pending_counter #(
  parameter  int MAX_PENDING = 3,
  localparam int CNT_WIDTH   = $clog2(MAX_PENDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic                 dec_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 is_zero_o,
  output logic                 is_one_o,
  output logic                 is_max_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 dec_ok, inc_ok;

  assign is_zero_o = (cnt_q == '0);
  assign is_one_o  = (cnt_q == CNT_WIDTH'(1));
  assign is_max_o  = (cnt_q == CNT_WIDTH'(MAX_PENDING));
  assign count_o   = cnt_q;

  // A retire at zero is an underflow and is dropped; an issue at the limit
  // is only accepted when a retire frees a slot in the same cycle.
  assign dec_ok = dec_i & ~is_zero_o;
  assign inc_ok = inc_i & (~is_max_o | dec_ok);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_ok && !dec_ok) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Read-side hazard tracker for the register file.
// Tracks per-register outstanding writes between issue and writeback and
// decides whether the instruction in decode may issue.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   issue_valid_in               decode presents an instruction
//   issue_ready_out              instruction may issue this cycle (comb.)
//   rs1_in/rs1_used_in           source 1 address / read enable
//   rs2_in/rs2_used_in           source 2 address / read enable
//   rd_in/rd_wr_in               destination address / write enable
//   wb_valid_in/wb_rd_in         writeback retiring a write this cycle
//   flush_in                     discard all pending writes
//   stall_out                    issue_valid_in & ~issue_ready_out
//   busy_out                     any pending write outstanding
//   err_out                      sticky writeback-underflow flag
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NUM_REGISTERS = rf_pkg::NUM_REGISTERS,
  parameter  int MAX_PENDING   = 3,
  localparam int OP_ADDR_WIDTH = $clog2(NUM_REGISTERS),
  localparam int CNT_WIDTH     = $clog2(MAX_PENDING + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid_in,
  output logic                     issue_ready_out,
  input  logic [OP_ADDR_WIDTH-1:0] rs1_in,
  input  logic                     rs1_used_in,
  input  logic [OP_ADDR_WIDTH-1:0] rs2_in,
  input  logic                     rs2_used_in,
  input  logic [OP_ADDR_WIDTH-1:0] rd_in,
  input  logic                     rd_wr_in,
  input  logic                     wb_valid_in,
  input  logic [OP_ADDR_WIDTH-1:0] wb_rd_in,
  input  logic                     flush_in,
  output logic                     stall_out,
  output logic                     busy_out,
  output logic                     err_out
);

  localparam logic [OP_ADDR_WIDTH-1:0] ZERO_ADDR = OP_ADDR_WIDTH'(ZERO_REG);

  logic [CNT_WIDTH-1:0]     cnt [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] is_zero, is_one, is_max, nonzero;
  logic [NUM_REGISTERS-1:0] inc, dec;

  logic raw1, raw2, waw_sat, fire, underflow;
  logic err_q, err_d;

  // Register 0 never holds a pending write.
  assign cnt[0]     = '0;
  assign is_zero[0] = 1'b1;
  assign is_one[0]  = 1'b0;
  assign is_max[0]  = 1'b0;
  assign inc[0]     = 1'b0;
  assign dec[0]     = 1'b0;
  assign nonzero[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGISTERS; r++) begin : g_cnt
    assign inc[r]     = fire & rd_wr_in & (rd_in == OP_ADDR_WIDTH'(r));
    assign dec[r]     = wb_valid_in & (wb_rd_in == OP_ADDR_WIDTH'(r));
    assign nonzero[r] = |cnt[r];

    reg_pending_counter #(
      .MAX_PENDING (MAX_PENDING)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc_i     (inc[r]),
      .dec_i     (dec[r]),
      .clr_i     (flush_in),
      .count_o   (cnt[r]),
      .is_zero_o (is_zero[r]),
      .is_one_o  (is_one[r]),
      .is_max_o  (is_max[r])
    );
  end

  // A source whose last pending write retires this cycle is readable: the
  // register file writes on the falling edge, ahead of the operand read.
  assign raw1 = rs1_used_in & (rs1_in != ZERO_ADDR) & ~is_zero[rs1_in]
              & ~(wb_valid_in & (wb_rd_in == rs1_in) & is_one[rs1_in]);
  assign raw2 = rs2_used_in & (rs2_in != ZERO_ADDR) & ~is_zero[rs2_in]
              & ~(wb_valid_in & (wb_rd_in == rs2_in) & is_one[rs2_in]);

  assign waw_sat = rd_wr_in & (rd_in != ZERO_ADDR) & is_max[rd_in]
                 & ~(wb_valid_in & (wb_rd_in == rd_in));

  assign issue_ready_out = ~rst & ~flush_in & ~raw1 & ~raw2 & ~waw_sat;
  assign fire            = issue_valid_in & issue_ready_out;
  assign stall_out       = issue_valid_in & ~issue_ready_out;

  // Writebacks in a flush cycle are discarded along with the counters.
  assign underflow = wb_valid_in & ~flush_in & (wb_rd_in != ZERO_ADDR)
                   & is_zero[wb_rd_in];

  assign err_d = err_q | underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_out  = err_q;
  assign busy_out = |nonzero;

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid_in;
  logic       issue_ready_out;
  logic [4:0] rs1_in, rs2_in, rd_in, wb_rd_in;
  logic       rs1_used_in, rs2_used_in, rd_wr_in;
  logic       wb_valid_in, flush_in;
  logic       stall_out, busy_out, err_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid_in  (issue_valid_in),
    .issue_ready_out (issue_ready_out),
    .rs1_in          (rs1_in),
    .rs1_used_in     (rs1_used_in),
    .rs2_in          (rs2_in),
    .rs2_used_in     (rs2_used_in),
    .rd_in           (rd_in),
    .rd_wr_in        (rd_wr_in),
    .wb_valid_in     (wb_valid_in),
    .wb_rd_in        (wb_rd_in),
    .flush_in        (flush_in),
    .stall_out       (stall_out),
    .busy_out        (busy_out),
    .err_out         (err_out)
  );

  task automatic idle();
    issue_valid_in = 0; rs1_in = 0; rs1_used_in = 0; rs2_in = 0; rs2_used_in = 0;
    rd_in = 0; rd_wr_in = 0; wb_valid_in = 0; wb_rd_in = 0; flush_in = 0;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge and are
  // checked 1 more unit later, well away from the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] wbrd, input logic wbv);
    idle();
    issue_valid_in = 1; rd_in = rd; rd_wr_in = 1; wb_valid_in = wbv; wb_rd_in = wbrd;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; issue_valid_in = 1; rd_wr_in = 1; rd_in = 5'd6;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (issue_ready_out !== 1'b0) begin
        bad++; $display("FAIL reset_ready cyc%0d got=%b exp=0", i, issue_ready_out);
      end
      total++;
      if (stall_out !== 1'b1) begin
        bad++; $display("FAIL reset_stall cyc%0d got=%b exp=1", i, stall_out);
      end
      step();
    end
    rst = 0;
    #1;
    total++;
    if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
    total++;
    if (err_out !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_out); end
    rs1_in = 5'd12; rs1_used_in = 1; rs2_in = 5'd31; rs2_used_in = 1; rd_in = 5'd17;
    #1;
    total++;
    if (issue_ready_out !== 1'b1) begin
      bad++; $display("FAIL reset_ready_after got=%b exp=1", issue_ready_out);
    end
    idle();
    step();
  endtask

  task automatic test_raw();
    issue(5'd5, 5'd0, 0);
    #1;
    total++;
    if (issue_ready_out !== 1'b1) begin bad++; $display("FAIL raw_issue got=%b exp=1", issue_ready_out); end
    step();
    idle();
    issue_valid_in = 1; rs1_in = 5'd5; rs1_used_in = 1;
    #1;
    total++;
    if (issue_ready_out !== 1'b0) begin bad++; $display("FAIL raw_ready got=%b exp=0", issue_ready_out); end
    total++;
    if (stall_out !== 1'b1) begin bad++; $display("FAIL raw_stall got=%b exp=1", stall_out); end
    total++;
    if (busy_out !== 1'b1) begin bad++; $display("FAIL raw_busy got=%b exp=1", busy_out); end
    wb_valid_in = 1; wb_rd_in = 5'd5;
    #1;
    total++;
    if (issue_ready_out !== 1'b1) begin bad++; $display("FAIL raw_release got=%b exp=1", issue_ready_out); end
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL raw_release_stall got=%b exp=0", stall_out); end
    step();
    idle();
    #1;
    total++;
    if (busy_out !== 1'b0) begin bad++; $display("FAIL raw_busy_after got=%b exp=0", busy_out); end
    total++;
    if (err_out !== 1'b0) begin bad++; $display("FAIL raw_err got=%b exp=0", err_out); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      issue(5'd7, 5'd0, 0);
      #1;
      total++;
      if (issue_ready_out !== 1'b1) begin
        bad++; $display("FAIL sat_fill%0d got=%b exp=1", i, issue_ready_out);
      end
      step();
    end
    issue(5'd7, 5'd0, 0);
    #1;
    total++;
    if (issue_ready_out !== 1'b0) begin bad++; $display("FAIL sat_block got=%b exp=0", issue_ready_out); end
    wb_valid_in = 1; wb_rd_in = 5'd7;
    #1;
    total++;
    if (issue_ready_out !== 1'b1) begin bad++; $display("FAIL sat_wb_fire got=%b exp=1", issue_ready_out); end
    step();
    // count must still be 3: another rd=7 without writeback is blocked
    issue(5'd7, 5'd0, 0);
    #1;
    total++;
    if (issue_ready_out !== 1'b0) begin bad++; $display("FAIL sat_still3 got=%b exp=0", issue_ready_out); end
    idle();
    for (int i = 0; i < 3; i++) begin
      wb_valid_in = 1; wb_rd_in = 5'd7;
      step();
    end
    idle();
    #1;
    total++;
    if (busy_out !== 1'b0) begin bad++; $display("FAIL sat_drain_busy got=%b exp=0", busy_out); end
    total++;
    if (err_out !== 1'b0) begin bad++; $display("FAIL sat_drain_err got=%b exp=0", err_out); end
  endtask

  task automatic test_zero_reg();
    for (int i = 0; i < 4; i++) begin
      issue(5'd0, 5'd0, 0);
      rs1_used_in = 1; rs2_used_in = 1;
      #1;
      total++;
      if (issue_ready_out !== 1'b1) begin
        bad++; $display("FAIL zero_ready%0d got=%b exp=1", i, issue_ready_out);
      end
      step();
    end
    idle();
    wb_valid_in = 1; wb_rd_in = 5'd0;
    #1;
    total++;
    if (busy_out !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b exp=0", busy_out); end
    step();
    idle();
    #1;
    total++;
    if (err_out !== 1'b0) begin bad++; $display("FAIL zero_wb_err got=%b exp=0", err_out); end
  endtask

  task automatic test_flush();
    issue(5'd3, 5'd0, 0);
    step();
    issue(5'd4, 5'd0, 0);
    step();
    idle();
    issue_valid_in = 1; flush_in = 1;
    #1;
    total++;
    if (busy_out !== 1'b1) begin bad++; $display("FAIL flush_busy_before got=%b exp=1", busy_out); end
    total++;
    if (issue_ready_out !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", issue_ready_out); end
    step();
    idle();
    #1;
    total++;
    if (busy_out !== 1'b0) begin bad++; $display("FAIL flush_busy_after got=%b exp=0", busy_out); end
    total++;
    if (err_out !== 1'b0) begin bad++; $display("FAIL flush_err_pre got=%b exp=0", err_out); end
    wb_valid_in = 1; wb_rd_in = 5'd3;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (err_out !== 1'b1) begin bad++; $display("FAIL flush_err_sticky%0d got=%b exp=1", i, err_out); end
      step();
    end
    rst = 1;
    step();
    rst = 0;
    #1;
    total++;
    if (err_out !== 1'b0) begin bad++; $display("FAIL flush_err_rst got=%b exp=0", err_out); end
  endtask

  task automatic test_back_to_back();
    issue(5'd9, 5'd0, 0);
    step();
    issue(5'd9, 5'd0, 0);
    step();
    // cnt[9]=2: issue and retire together keep it at 2
    issue(5'd9, 5'd9, 1);
    #1;
    total++;
    if (issue_ready_out !== 1'b1) begin bad++; $display("FAIL b2b_incdec got=%b exp=1", issue_ready_out); end
    step();
    idle();
    issue_valid_in = 1; rs2_in = 5'd9; rs2_used_in = 1; wb_valid_in = 1; wb_rd_in = 5'd9;
    #1;
    total++;
    if (issue_ready_out !== 1'b0) begin bad++; $display("FAIL b2b_cnt2_stall got=%b exp=0", issue_ready_out); end
    total++;
    if (stall_out !== 1'b1) begin bad++; $display("FAIL b2b_cnt2_stallout got=%b exp=1", stall_out); end
    step();
    // that retire dropped cnt[9] to 1; the next retire releases it
    #1;
    total++;
    if (issue_ready_out !== 1'b1) begin bad++; $display("FAIL b2b_cnt1_release got=%b exp=1", issue_ready_out); end
    step();
    idle();
    #1;
    total++;
    if (busy_out !== 1'b0) begin bad++; $display("FAIL b2b_busy_after got=%b exp=0", busy_out); end
    total++;
    if (err_out !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b exp=0", err_out); end
  endtask

  initial begin
    idle();
    rst = 1;
    #1;
    test_reset();
    test_raw();
    test_saturation();
    test_zero_reg();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
